// File: rtl/han_carlson_sub_pipe.sv
// ============================================================================
// Module   : han_carlson_sub_pipe
// Purpose  : Three-stage Han-Carlson subtractor D = A - B - Bin, valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module han_carlson_sub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int c_MSB = WIDTH - 1;

  logic r_v1, r_v2, r_v3;
  logic w_ready1, w_ready2, w_ready3;

  assign w_ready3  = out_ready | ~r_v3;
  assign w_ready2  = w_ready3 | ~r_v2;
  assign w_ready1  = w_ready2 | ~r_v1;
  assign in_ready  = w_ready1;
  assign out_valid = r_v3;

  // Stage 1: generate/propagate of A + ~B, carry-in is the inverted borrow
  logic [WIDTH-1:0] r_g1, r_p1;
  logic             r_c1, r_am1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1  <= 1'b0;
      r_g1  <= '0;
      r_p1  <= '0;
      r_c1  <= 1'b0;
      r_am1 <= 1'b0;
    end else if (w_ready1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_g1  <= A & ~B;
        r_p1  <= A ^ ~B;
        r_c1  <= ~Bin;
        r_am1 <= A[c_MSB];
      end
    end
  end

  // Stage 2 prefix: carry-in folded into column 0, odd columns grow to 8-bit groups
  logic [WIDTH-1:0] w_g2, w_p2;

  always_comb begin
    w_g2    = r_g1;
    w_p2    = r_p1;
    w_g2[0] = r_g1[0] | (r_p1[0] & r_c1);
    for (int i = WIDTH - 1; i >= 1; i -= 2) begin
      w_g2[i] = w_g2[i] | (w_p2[i] & w_g2[i-1]);
      w_p2[i] = w_p2[i] & w_p2[i-1];
    end
    for (int d = 2; d <= 4; d *= 2) begin
      for (int i = WIDTH - 1; i > d; i -= 2) begin
        w_g2[i] = w_g2[i] | (w_p2[i] & w_g2[i-d]);
        w_p2[i] = w_p2[i] & w_p2[i-d];
      end
    end
  end

  logic [WIDTH-1:0] r_g2, r_p2, r_x2;
  logic             r_c2, r_am2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2  <= 1'b0;
      r_g2  <= '0;
      r_p2  <= '0;
      r_x2  <= '0;
      r_c2  <= 1'b0;
      r_am2 <= 1'b0;
    end else if (w_ready2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_g2  <= w_g2;
        r_p2  <= w_p2;
        r_x2  <= r_p1;
        r_c2  <= r_c1;
        r_am2 <= r_am1;
      end
    end
  end

  // Stage 3: remaining odd levels, then even columns take carry from their left neighbour
  logic [WIDTH-1:0] w_g3, w_p3, w_c3, w_d3;
  logic             w_unused;

  always_comb begin
    w_g3 = r_g2;
    w_p3 = r_p2;
    for (int d = 8; d < WIDTH; d *= 2) begin
      for (int i = WIDTH - 1; i > d; i -= 2) begin
        w_g3[i] = w_g3[i] | (w_p3[i] & w_g3[i-d]);
        w_p3[i] = w_p3[i] & w_p3[i-d];
      end
    end
    for (int i = 2; i < WIDTH; i += 2) begin
      w_g3[i] = r_g2[i] | (r_x2[i] & w_g3[i-1]);
    end
  end

  assign w_c3     = {w_g3[WIDTH-2:0], r_c2};
  assign w_d3     = r_x2 ^ w_c3;
  assign w_unused = ^w_p3;

  logic [WIDTH-1:0] r_d;
  logic             r_bout, r_z, r_n, r_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v3   <= 1'b0;
      r_d    <= '0;
      r_bout <= 1'b0;
      r_z    <= 1'b0;
      r_n    <= 1'b0;
      r_v    <= 1'b0;
    end else if (w_ready3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_d    <= w_d3;
        r_bout <= ~w_g3[c_MSB];
        r_z    <= (w_d3 == '0);
        r_n    <= w_d3[c_MSB];
        // operand signs differ exactly when the MSB xnor-propagate is 0
        r_v    <= ~r_x2[c_MSB] & (w_d3[c_MSB] ^ r_am2);
      end
    end
  end

  assign D    = r_d;
  assign Bout = r_bout;
  assign Z    = r_z;
  assign N    = r_n;
  assign V    = r_v;

endmodule

`default_nettype wire

// File: tb/tb_han_carlson_sub_pipe.sv
// Scoreboard bench for han_carlson_sub_pipe: directed cases at WIDTH=32,
// then randomized streams at WIDTH=32 and WIDTH=8 in parallel.
`timescale 1ns/1ps
`default_nettype none

module tb_han_carlson_sub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a32, b32, d32;
  logic        bin32, iv32, ir32, bout32, z32, n32, v32, ov32, or32;
  logic [7:0]  a8, b8, d8;
  logic        bin8, iv8, ir8, bout8, z8, n8, v8, ov8, or8;

  han_carlson_sub_pipe #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .A(a32), .B(b32), .Bin(bin32), .in_valid(iv32),
    .in_ready(ir32), .D(d32), .Bout(bout32), .Z(z32), .N(n32), .V(v32),
    .out_valid(ov32), .out_ready(or32)
  );

  han_carlson_sub_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Bin(bin8), .in_valid(iv8),
    .in_ready(ir8), .D(d8), .Bout(bout8), .Z(z8), .N(n8), .V(v8),
    .out_valid(ov8), .out_ready(or8)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {Bout, Z, N, V, D}
  function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic bin, input int w);
    logic [64:0] diff;
    logic [63:0] d, mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    diff = {1'b0, a} - {1'b0, b} - {64'd0, bin};
    d    = diff[63:0] & mask;
    return {diff[w], (d == 64'd0), d[w-1], (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]), d};
  endfunction

  logic [67:0] q32[$];
  logic [67:0] q8[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (ov32) begin
        if (q32.size() == 0) check("dut32_spurious_out", 1, 0);
        else begin
          check("dut32_D", {32'd0, d32}, q32[0][63:0]);
          check("dut32_flags", {60'd0, bout32, z32, n32, v32}, {60'd0, q32[0][67:64]});
          if (or32) void'(q32.pop_front());
        end
      end
      if (iv32 && ir32) q32.push_back(model({32'd0, a32}, {32'd0, b32}, bin32, 32));
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (ov8) begin
        if (q8.size() == 0) check("dut8_spurious_out", 1, 0);
        else begin
          check("dut8_D", {56'd0, d8}, q8[0][63:0]);
          check("dut8_flags", {60'd0, bout8, z8, n8, v8}, {60'd0, q8[0][67:64]});
          if (or8) void'(q8.pop_front());
        end
      end
      if (iv8 && ir8) q8.push_back(model({56'd0, a8}, {56'd0, b8}, bin8, 8));
    end
  end

  // One op into an empty pipe; checks latency, explicit result and single-cycle valid
  task automatic single32(input logic [31:0] a, input logic [31:0] b, input logic bin,
                          input logic [31:0] exp_d, input logic [3:0] exp_f);
    int k;
    or32 = 1'b1;
    @(posedge clk); #1;
    a32 = a; b32 = b; bin32 = bin; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    k = 1;
    while (!ov32 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, 3);
    check("direct_D", {32'd0, d32}, {32'd0, exp_d});
    check("direct_flags", {60'd0, bout32, z32, n32, v32}, {60'd0, exp_f});
    @(posedge clk); #1;
    check("one_cycle_valid", {63'd0, ov32}, 64'd0);
  endtask

  task automatic rand_run32();
    int acc = 0;
    int t = 0;
    int pick;
    while (acc < 10000 && t < 40000) begin
      @(posedge clk); #1;
      pick  = $urandom_range(7);
      iv32  = ($urandom_range(3) != 0);
      a32   = (pick == 0) ? 32'd0 : (pick == 1) ? 32'hFFFF_FFFF : $urandom;
      b32   = (pick == 2) ? a32 : (pick == 3) ? 32'hFFFF_FFFF : $urandom;
      bin32 = 1'($urandom_range(1));
      or32  = ($urandom_range(3) != 0);
      @(negedge clk);
      if (iv32 && ir32) acc++;
      t++;
    end
    @(posedge clk); #1;
    iv32 = 1'b0; or32 = 1'b1;
    t = 0;
    while (q32.size() != 0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("rand32_count", acc, 10000);
    check("rand32_drained", q32.size(), 0);
  endtask

  task automatic rand_run8();
    int acc = 0;
    int t = 0;
    int pick;
    while (acc < 10000 && t < 40000) begin
      @(posedge clk); #1;
      pick = $urandom_range(7);
      iv8  = ($urandom_range(3) != 0);
      a8   = (pick == 0) ? 8'd0 : (pick == 1) ? 8'hFF : 8'($urandom);
      b8   = (pick == 2) ? a8 : (pick == 3) ? 8'h80 : 8'($urandom);
      bin8 = 1'($urandom_range(1));
      or8  = ($urandom_range(3) != 0);
      @(negedge clk);
      if (iv8 && ir8) acc++;
      t++;
    end
    @(posedge clk); #1;
    iv8 = 1'b0; or8 = 1'b1;
    t = 0;
    while (q8.size() != 0 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    check("rand8_count", acc, 10000);
    check("rand8_drained", q8.size(), 0);
  endtask

  initial begin
    int sent;
    rst = 1'b1;
    a32 = '0; b32 = '0; bin32 = 1'b0; iv32 = 1'b0; or32 = 1'b1;
    a8  = '0; b8  = '0; bin8  = 1'b0; iv8  = 1'b0; or8  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {63'd0, ov32}, 64'd0);
    check("reset_D", {32'd0, d32}, 64'd0);
    check("reset_flags", {60'd0, bout32, z32, n32, v32}, 64'd0);
    check("reset_in_ready", {63'd0, ir32}, 64'd1);
    rst = 1'b0;

    single32(32'd5, 32'd3, 1'b0, 32'd2, 4'b0000);
    single32(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 4'b1010);
    single32(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 4'b0001);
    single32(32'd7, 32'd6, 1'b1, 32'd0, 4'b0100);
    single32(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 4'b1100);

    // Backpressure: out_ready low for cycles 0..7, five ops 10-1..10-5
    sent = 0;
    for (int c = 0; c < 40 && (sent < 5 || q32.size() != 0); c++) begin
      or32  = (c >= 8);
      iv32  = (sent < 5);
      a32   = 32'd10;
      b32   = 32'(sent + 1);
      bin32 = 1'b0;
      @(negedge clk);
      if (sent == 3 && c < 8) check("bp_in_ready_low", {63'd0, ir32}, 64'd0);
      if (c == 8) check("bp_in_ready_rise", {63'd0, ir32}, 64'd1);
      if (iv32 && ir32) sent++;
      @(posedge clk); #1;
    end
    iv32 = 1'b0; or32 = 1'b1;
    check("bp_all_sent", sent, 5);
    check("bp_drained", q32.size(), 0);

    // Asynchronous reset with three ops in flight
    or32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a32 = 32'(100 + i); b32 = 32'(i); bin32 = 1'b0; iv32 = 1'b1;
      @(posedge clk); #1;
    end
    iv32 = 1'b0;
    check("rst_pre_valid", {63'd0, ov32}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", {63'd0, ov32}, 64'd0);
    check("rst_D", {32'd0, d32}, 64'd0);
    check("rst_in_ready", {63'd0, ir32}, 64'd1);
    q32.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    single32(32'd20, 32'd4, 1'b0, 32'd16, 4'b0000);

    fork
      rand_run32();
      rand_run8();
    join

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/han_carlson_sub_pipe.md
# han_carlson_sub_pipe

Pipelined WIDTH-bit subtractor that computes D = A − B − Bin with borrow-out and Z/N/V flags. It is the borrow-domain counterpart of the combinational Han-Carlson adder in the arithmetic library: the same sparse Han-Carlson prefix tree, split across three register stages. Valid/ready handshakes on both sides let it sit between streaming producers and consumers in the datapath, accepting one operation per cycle under full throughput.

## Interface
- WIDTH, 32, operand width; legal values 8, 16, 32, 64 (power of two).
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- A  in  WIDTH  minuend.
- B  in  WIDTH  subtrahend.
- Bin  in  1  borrow-in.
- in_valid  in  1  A/B/Bin valid.
- in_ready  out  1  block can accept this cycle.
- D  out  WIDTH  difference, A − B − Bin mod 2^WIDTH.
- Bout  out  1  borrow-out: 1 iff unsigned A < B + Bin.
- Z  out  1  D == 0.
- N  out  1  D[WIDTH-1].
- V  out  1  signed overflow: A[W-1] != B[W-1] and D[W-1] != A[W-1].
- out_valid  out  1  D/Bout/flags valid.
- out_ready  in  1  consumer accepts this cycle.

## Operation
- Arithmetic: D = A + ~B + ~Bin. The internal carry-in is ~Bin, and Bout = ~carry-out of the MSB.
- Stage 1 (S1) registers per-bit Gi = A&~B, Pi = A^~B, and the carry-in.
- Stage 2 (S2) registers the Han-Carlson odd-column prefix levels with spans 2, 4 and 8.
- Stage 3 (S3) completes the odd-column levels with spans 16 and up, then the final even-column merge. It forms the carries, D, Bout and flags, and registers them as the outputs.
- Each stage has a valid bit v1/v2/v3.
  - ready3 = out_ready | ~v3
  - ready2 = ready3 | ~v2
  - ready1 = ready2 | ~v1
  - in_ready = ready1
- Stage k loads when ready_k; v_k takes the upstream valid on load.
- The combinational path out_ready → in_ready is permitted and documented.
- Transfer on the input occurs when in_valid & in_ready. Transfer on the output occurs when out_valid & out_ready. out_valid = v3.
- Stalled stages hold their data and valid unchanged. No bubble is inserted while a stage is stalled.
- Results emerge in strict acceptance order. No operation is dropped or duplicated.
- Reset, asynchronous, takes effect immediately:
  - v1, v2, v3 = 0
  - D = 0, Bout = Z = N = V = 0, out_valid = 0
- in_ready is 1 during reset, since all stages are empty.
- Reset mid-operation discards all in-flight operations.
- Upstream is not required to hold A/B/Bin once transferred.
- While out_valid & ~out_ready, D/Bout/Z/N/V are stable.

## Timing
- Latency: an operation transferred in cycle n appears with out_valid = 1 in cycle n+3, provided out_ready was 1 (or the stages were empty) in between.
- Throughput is 1 op/cycle while out_ready = 1.
- With out_ready held low, the pipe fills after 3 accepted ops. in_ready falls combinationally in the cycle the 3rd op sits in S1 with S2/S3 full.
- On out_ready returning high, in_ready rises in the same cycle, with no dead cycle.
- Simultaneous input and output transfer with a full pipe is legal and keeps occupancy at 3.
- Empty pipe with in_valid = 0: all v = 0, outputs hold their last values, and out_valid = 0.
- Flags and Bout are registered with D in S3 and are never combinational from the inputs.

## Test plan
- 5 − 3, Bin=0, out_ready=1 → cycle n+3: D=0x00000002, Bout=0, Z=0, N=0, V=0, out_valid=1 for one cycle.
- 0x00000000 − 0x00000001, Bin=0 → D=0xFFFFFFFF, Bout=1, N=1, V=0, Z=0.
- 0x80000000 − 0x00000001 → D=0x7FFFFFFF, V=1, N=0, Bout=0.
- 7 − 6, Bin=1 → D=0, Z=1, Bout=0.
- 0x00000000 − 0xFFFFFFFF, Bin=1 → D=0, Z=1, Bout=1.
- Backpressure and ordering:
  - Stimulus: stream 5 ops (10−1, 10−2, …, 10−5) with out_ready=0 for cycles 0–7, then 1.
  - Required: in_ready low once 3 ops are held.
  - Required: outputs 9, 8, 7, 6, 5 in order, each held stable while stalled, none lost or repeated.
- Reset mid-flight:
  - Stimulus: assert rst asynchronously with 3 ops in flight.
  - Required: out_valid and D fall to 0 immediately.
  - Required: after deassert, the first new op (20−4) appears 3 cycles after acceptance with D=16, with no stale results.
- Randomized 10k ops with random in_valid/out_ready against a reference model, WIDTH=8 and 32, including Bin=1 cases.
